lcd_frame_scheduler: RTL and testbench

Frame sequencer and double-buffer arbiter feeding the LCD pixel writer. Streams one full frame per pass from the current front framebuffer through a single-port read interface, drives the writer's `rgb`/`data_valid` inputs and consumes its `data_req` strobe. Exchanges front/back buffers with the renderer only at frame boundaries, so a displayed frame is never torn.

---
 rtl/lcd_frame_scheduler_if.sv | 29 ++
 rtl/lcd_frame_scheduler.sv | 107 ++++++++++
 tb/tb_lcd_frame_scheduler.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/lcd_frame_scheduler_if.sv
// Scheduler-side bundle: pixel-writer handshake, framebuffer read port and
// renderer swap handshake.
interface lcd_frame_scheduler_if #(
    parameter int ADDR_W = 18
) ();
    // Handshake: data_valid stays high for the whole frame; a pixel moves only
    // on a rising edge where data_valid & data_req, and the next pixel appears
    // on rgb after that same edge. swap_req is a level held until swap_ack.
    logic              data_req;
    logic              data_valid;
    logic [23:0]       rgb;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [23:0]       rd_data;
    logic              swap_req;
    logic              swap_ack;
    logic              front_sel;
    logic              frame_done;

    modport master (
        input  data_req, rd_data, swap_req,
        output data_valid, rgb, rd_en, rd_addr, swap_ack, front_sel, frame_done
    );

    modport slave (
        output data_req, rd_data, swap_req,
        input  data_valid, rgb, rd_en, rd_addr, swap_ack, front_sel, frame_done
    );
endinterface

// File: rtl/lcd_frame_scheduler.sv
// Frame sequencer and double-buffer arbiter: streams the front framebuffer to
// the LCD pixel writer and swaps buffers only between frames.
module lcd_frame_scheduler #(
    parameter int                HOR_PIX    = 480,
    parameter int                VER_PIX    = 272,
    parameter int                ADDR_W     = 18,
    parameter logic [ADDR_W-1:0] BUF_B_BASE = 18'd131072
) (
    input  logic                 clk_12mhz,
    input  logic                 rst,
    input  logic                 enable,
    output logic                 busy,
    output logic [1:0]           dbg_state,
    lcd_frame_scheduler_if.master bus
);
    localparam int          NPIX     = HOR_PIX * VER_PIX;
    localparam logic [17:0] LAST_IDX = 18'(NPIX - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        SWAP   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [17:0]       idx;
    logic              consume;
    logic              last_pix;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] swap_base;

    assign consume   = bus.data_valid & bus.data_req;
    assign last_pix  = (idx == LAST_IDX);
    assign base      = bus.front_sel ? BUF_B_BASE : '0;
    // Base the next PRIME will read, accounting for a swap applied in SWAP.
    assign swap_base = (bus.front_sel ^ bus.swap_req) ? BUF_B_BASE : '0;
    assign bus.rgb   = bus.rd_data;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        state_next = state;
        bus.rd_en  = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_next = PRIME;
            end
            PRIME: begin
                bus.rd_en  = 1'b1;
                state_next = STREAM;
            end
            STREAM: begin
                bus.rd_en = consume & ~last_pix;
                if (consume && last_pix) state_next = SWAP;
            end
            SWAP: begin
                state_next = enable ? PRIME : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_12mhz or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            idx            <= '0;
            bus.rd_addr    <= '0;
            bus.data_valid <= 1'b0;
            bus.front_sel  <= 1'b0;
            bus.swap_ack   <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            state          <= state_next;
            bus.swap_ack   <= 1'b0;
            bus.frame_done <= 1'b0;
            case (state)
                IDLE: bus.rd_addr <= base;
                PRIME: begin
                    bus.rd_addr    <= bus.rd_addr + ADDR_W'(1);
                    idx            <= '0;
                    bus.data_valid <= 1'b1;
                end
                STREAM: begin
                    if (consume) begin
                        if (last_pix) begin
                            bus.data_valid <= 1'b0;
                            bus.frame_done <= 1'b1;
                        end else begin
                            idx         <= idx + 18'd1;
                            bus.rd_addr <= bus.rd_addr + ADDR_W'(1);
                        end
                    end
                end
                SWAP: begin
                    bus.rd_addr <= swap_base;
                    if (bus.swap_req) begin
                        bus.front_sel <= ~bus.front_sel;
                        bus.swap_ack  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Bench for lcd_frame_scheduler: 4x2 frames from a two-buffer memory model,
// pixel and address expectations derived per frame from the buffer contents.
module tb_lcd_frame_scheduler;
    localparam int                HP     = 4;
    localparam int                VP     = 2;
    localparam int                N      = HP * VP;
    localparam int                AW     = 18;
    localparam logic [AW-1:0]     B_BASE = 18'd131072;

    logic       clk_12mhz = 1'b0;
    logic       rst       = 1'b0;
    logic       enable    = 1'b0;
    logic       busy;
    logic [1:0] dbg_state;

    int         total = 0;
    int         bad   = 0;
    int         pat_cnt = 0;
    bit         model_front = 1'b0;
    logic [23:0]   exp_q[$];
    logic [AW-1:0] rd_log[$];

    lcd_frame_scheduler_if #(.ADDR_W(AW)) bus ();

    lcd_frame_scheduler #(
        .HOR_PIX(HP), .VER_PIX(VP), .ADDR_W(AW), .BUF_B_BASE(B_BASE)
    ) dut (
        .clk_12mhz(clk_12mhz),
        .rst(rst),
        .enable(enable),
        .busy(busy),
        .dbg_state(dbg_state),
        .bus(bus)
    );

    always #5 clk_12mhz = ~clk_12mhz;

    // Buffer A word i = i, buffer B word i = 0x100 + i.
    function automatic logic [23:0] mem_word(input logic [AW-1:0] a);
        if (a >= B_BASE) return 24'h100 + 24'(a - B_BASE);
        return 24'(a);
    endfunction

    always @(posedge clk_12mhz) begin
        if (bus.rd_en) begin
            bus.rd_data <= mem_word(bus.rd_addr);
            rd_log.push_back(bus.rd_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_12mhz);
        #1;
        pat_cnt++;
    endtask

    // Runs one frame; swap_at/drop_at/rst_at are consume counts (0 = never).
    task automatic run_frame(input int swap_at, input int drop_at, input int rst_at, input bit rand_req);
        int            n_cons;
        bit            started;
        bit            aborted;
        bit            exp_swap;
        bit            en_now;
        logic [AW-1:0] base;
        n_cons  = 0;
        started = 0;
        aborted = 0;
        base    = model_front ? B_BASE : '0;
        exp_q.delete();
        for (int i = 0; i < N; i++)
            exp_q.push_back(model_front ? 24'h100 + 24'(i) : 24'(i));
        for (int cyc = 0; cyc < 300 && n_cons < N && !aborted; cyc++) begin
            if (bus.data_valid) started = 1;
            if (started) check("dv_held", bus.data_valid, 1);
            check("no_early_done", bus.frame_done, 0);
            check("front_stable", bus.front_sel, model_front);
            bus.data_req = rand_req ? ($urandom_range(0, 3) != 0) : ((pat_cnt % 11) < 8);
            if (bus.data_valid && bus.data_req) begin
                check("rgb", bus.rgb, exp_q.pop_front());
                n_cons++;
                if (n_cons == swap_at) bus.swap_req = 1'b1;
                if (n_cons == drop_at) enable = 1'b0;
                if (n_cons == rst_at) begin
                    #2 rst = 1'b0;
                    #1;
                    check("rst_dv", bus.data_valid, 0);
                    check("rst_rd_addr", bus.rd_addr, 0);
                    check("rst_front", bus.front_sel, 0);
                    check("rst_ack", bus.swap_ack, 0);
                    check("rst_done", bus.frame_done, 0);
                    check("rst_busy", busy, 0);
                    check("rst_rd_en", bus.rd_en, 0);
                    model_front  = 1'b0;
                    bus.swap_req = 1'b0;
                    bus.data_req = 1'b0;
                    step();
                    rst = 1'b1;
                    rd_log.delete();
                    exp_q.delete();
                    aborted = 1;
                end
            end
            if (!aborted) step();
        end
        if (!aborted) begin
            check("frame_consumes", n_cons, N);
            check("done_pulse", bus.frame_done, 1);
            check("dv_gap0", bus.data_valid, 0);
            check("busy_swap", busy, 1);
            check("rd_count", rd_log.size(), N);
            for (int i = 0; i < N; i++)
                check("rd_addr_seq", (i < rd_log.size()) ? 32'(rd_log[i]) : 32'hffff_ffff,
                      32'(base) + 32'(i));
            rd_log.delete();
            exp_swap = bus.swap_req;
            en_now   = enable;
            if (exp_swap) model_front = ~model_front;
            step();
            check("swap_ack", bus.swap_ack, exp_swap);
            check("front_sel", bus.front_sel, model_front);
            check("done_single", bus.frame_done, 0);
            check("dv_gap1", bus.data_valid, 0);
            check("busy_after_swap", busy, en_now);
            if (exp_swap) bus.swap_req = 1'b0;
            if (en_now) begin
                step();
                check("dv_back", bus.data_valid, 1);
                check("ack_single", bus.swap_ack, 0);
            end
        end
    endtask

    initial begin
        bus.data_req = 1'b0;
        bus.swap_req = 1'b0;
        repeat (2) step();
        check("reset_dv", bus.data_valid, 0);
        check("reset_rd_addr", bus.rd_addr, 0);
        check("reset_front", bus.front_sel, 0);
        check("reset_ack", bus.swap_ack, 0);
        check("reset_done", bus.frame_done, 0);
        check("reset_busy", busy, 0);
        check("reset_rd_en", bus.rd_en, 0);
        rst = 1'b1;
        repeat (3) begin
            step();
            check("idle_busy", busy, 0);
            check("idle_rd_en", bus.rd_en, 0);
        end
        enable  = 1'b1;
        pat_cnt = 0;
        run_frame(0, 0, 0, 1'b0);
        run_frame(3, 0, 0, 1'b1);
        run_frame(0, 2, 0, 1'b1);
        repeat (4) begin
            step();
            check("off_busy", busy, 0);
            check("off_dv", bus.data_valid, 0);
            check("off_rd_en", bus.rd_en, 0);
        end
        enable = 1'b1;
        run_frame(2, 0, 6, 1'b1);
        run_frame(int'($urandom_range(1, N)), 0, 0, 1'b1);
        run_frame(0, 0, 0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
